// File: rtl/uart_rx_if.sv
// Bus-side view of the UART receiver: received byte, status flags and the read acknowledge.
// available acts as valid for data; data_read is a one-cycle acknowledge that consumes data
// whenever it is high, and needs no ready-style backpressure from the receiver.
interface uart_rx_if;
  logic [7:0] data;
  logic       available;
  logic       data_read;
  logic       framing_err;
  logic       overrun;
  logic       busy;

  modport slave (
    input  data_read,
    output data, available, framing_err, overrun, busy
  );

  modport master (
    output data_read,
    input  data, available, framing_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, oversampled by a one-cycle sample tick from the baud generator.
// Each byte is held with an available flag; framing and overrun errors are sticky until data_read.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       sample_tick,
  input  logic       rx,
  uart_rx_if.slave   bus,
  output logic [1:0] dbg_state_o
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, rx_s_q;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            avail_q, avail_d;
  logic            fe_q, fe_d;
  logic            ov_q, ov_d;
  logic            stop_good, stop_bad;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      avail_q    <= 1'b0;
      fe_q       <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      sync1_q    <= rx;
      rx_s_q     <= sync1_q;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      avail_q    <= avail_d;
      fe_q       <= fe_d;
      ov_q       <= ov_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
    if (sample_tick) begin
      case (state_q)
        IDLE: begin
          tick_cnt_d = '0;
          if (!rx_s_q) state_d = START;
        end
        START: begin
          if (tick_cnt_q == HALF_M1) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            // A start bit that is high again by its midpoint is treated as line noise.
            state_d    = rx_s_q ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            shift_d    = {rx_s_q, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) state_d = STOP;
            else                   bit_cnt_d = bit_cnt_q + 3'd1;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt_q == FULL_M1) begin
            tick_cnt_d = '0;
            state_d    = IDLE;
            stop_good  = rx_s_q;
            stop_bad   = !rx_s_q;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Status updates: a read clears everything first, then a completing frame may set flags again.
  always_comb begin
    data_d  = data_q;
    avail_d = bus.data_read ? 1'b0 : avail_q;
    fe_d    = bus.data_read ? 1'b0 : fe_q;
    ov_d    = bus.data_read ? 1'b0 : ov_q;
    if (stop_good) begin
      data_d  = shift_q;
      avail_d = 1'b1;
      if (avail_q && !bus.data_read) ov_d = 1'b1;
    end
    if (stop_bad) fe_d = 1'b1;
  end

  assign bus.data        = data_q;
  assign bus.available   = avail_q;
  assign bus.framing_err = fe_q;
  assign bus.overrun     = ov_q;
  assign bus.busy        = (state_q != IDLE);
  assign dbg_state_o     = state_q;
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, the receive-side counterpart of the UART transmitter in the bus-attached UART peripheral. It oversamples the `rx` pin using a one-cycle tick supplied by the baud generator. It recovers 8N1 frames (start, 8 data bits LSB first, 1 stop) and presents each byte with an `available` flag, which the bus interface clears by pulsing `data_read`. Framing and overrun errors are flagged for the status register.

## Interface
- `OVERSAMPLE`, default 16: sample ticks per bit period. Must be even, range 4..256. Tick counter width is $clog2(OVERSAMPLE).
- `clk` input 1: system clock; all state on its rising edge.
- `nrst` input 1: asynchronous active-low reset.
- `sample_tick` input 1: one-`clk` pulse at OVERSAMPLE × baud rate; state advances only on cycles where it is high.
- `rx` input 1: serial line, asynchronous to `clk`, idle high.
- `data` output 8: last correctly framed byte.
- `available` output 1: `data` holds an unread byte.
- `data_read` input 1: one-cycle acknowledge from the bus side; consumes `data`.
- `framing_err` output 1: sticky; stop bit sampled low.
- `overrun` output 1: sticky; a new byte replaced an unread one.
- `busy` output 1: frame reception in progress (state ≠ IDLE).

## Operation
- Synchronizer: two flops on `rx`, both reset to 1; the output is `rx_s`. All line decisions use `rx_s`.
- State machine is clocked every `clk` but advances only on `sample_tick`. Counters: `tick_cnt`, `bit_cnt[2:0]`, `shift[7:0]`.
- IDLE: on a tick with `rx_s`=0 → START, `tick_cnt`=0.
- START: each tick increments `tick_cnt`. On the tick where `tick_cnt`=OVERSAMPLE/2−1 (mid start bit):
  - if `rx_s`=0 → DATA, with `tick_cnt`=0 and `bit_cnt`=0;
  - else → IDLE (glitch rejected; no flags change).
- DATA: each tick increments `tick_cnt`. On the tick where `tick_cnt`=OVERSAMPLE−1:
  - `shift` <= {`rx_s`, `shift[7:1]`} and `tick_cnt`=0;
  - if `bit_cnt`=7 → STOP, else `bit_cnt`+1.
- STOP: on the tick where `tick_cnt`=OVERSAMPLE−1 (mid stop bit) → IDLE in all cases.
  - If `rx_s`=1: `data`<=`shift` and `available`<=1. If `available` was already 1 and `data_read` is not high this cycle, `overrun`<=1.
  - If `rx_s`=0: `framing_err`<=1. `data` and `available` are left unchanged.
- Because the machine returns to IDLE at mid stop bit, a start edge arriving immediately after the stop bit is detected.
- `data_read`=1 clears `available`, `overrun` and `framing_err` in the same cycle it is sampled.
  - If a flag is set in that same cycle, set wins.
  - If a good byte completes in that same cycle, `available` ends at 1 and `overrun` is not set.
- `data_read` while `available`=0 has no effect beyond clearing the error flags.
- `rx` and `data_read` are ignored on non-tick cycles only for FSM purposes; `data_read` is honoured on every `clk` cycle.

## Timing
- Reset values (asserted asynchronously while `nrst`=0):
  - state IDLE, all counters 0, `shift`=0x00;
  - synchronizer flops 1;
  - `data`=0x00, `available`=0, `framing_err`=0, `overrun`=0, `busy`=0.
- Reset mid-frame aborts the frame with no flag updates. Reception resumes with the first falling edge after `nrst` rises.
- Synchronizer latency: 2 `clk` cycles from `rx` to `rx_s`.
- Take tick T0 as the first tick on which IDLE sees `rx_s`=0. Samples then occur at:
  - start bit: T0+OVERSAMPLE/2;
  - data bit k (0..7): T0+OVERSAMPLE/2+OVERSAMPLE·(k+1);
  - stop bit: T0+OVERSAMPLE/2+9·OVERSAMPLE. With OVERSAMPLE=16 this is T0+152.
- `data`, `available` and the flags are registered: they change on the `clk` edge of the stop-sample tick and are visible the following cycle.
- `busy` rises on the clock edge of the T0 tick and falls on the clock edge of the stop-sample tick, or of the start-sample tick if the start bit is rejected.

## Test plan
- OVERSAMPLE=16, one tick every 4 clks, send 0xA5 with stop=1 → `data`=0xA5 and `available`=1 exactly after tick T0+152; `framing_err`=0, `overrun`=0, `busy`=0 afterwards.
- Glitch: `rx` low for 4 ticks, then high → FSM returns to IDLE at T0+8; `available`=0, `data`=0x00, no flags set.
- Bad stop: send 0x3C with stop bit held 0 → `framing_err`=1, `data` unchanged (0x00), `available`=0. A subsequent `data_read` pulse clears `framing_err`.
- Overrun: send 0x11 then 0x22 back-to-back with no `data_read` → `data`=0x22, `available`=1, `overrun`=1. Then a `data_read` pulse → `available`=0, `overrun`=0.
- Collision: pulse `data_read` in the same clk as the stop-sample tick of 0x77 (0x11 previously unread) → `data`=0x77, `available`=1, `overrun`=0.
- Reset mid-frame: deassert `nrst` during data bit 4 → all outputs 0 immediately and `busy`=0. After release, send 0x5A → `data`=0x5A, `available`=1, no flags.
